d_cache_2way: RTL and testbench
===============================

// Module: d_cache_2way
// PURPOSE
//  Two-way set-associative, write-back, write-allocate data cache with one-word lines and LRU replacement.
//  Sits between the CPU MEM stage (p_* side) and the AXI bridge (m_* side), in the same slot as the current d_cache.
//  Addresses 0xA000_0000-0xBFFF_FFFF (a[31:29]==3'b101) bypass the cache; the block passes them through
//  with the physical address {3'b000, a[28:0]}.
// PARAMETERS
//  A_WIDTH   32                 address width
//  C_INDEX   `D_CACHE_INDEX     set-index bits; 2^C_INDEX sets x 2 ways; tag = A_WIDTH-C_INDEX-2 bits
// PORTS
//  clk       in   1      clock
//  rst       in   1      asynchronous reset, active-high
//  p_a       in   32     CPU byte address
//  p_dout    in   32     CPU store data
//  p_din     out  32     load data to CPU
//  p_strobe  in   1      request valid; held until p_ready
//  p_wen     in   4      byte enables for stores (bit3 = [31:24])
//  p_size    in   2      0 = byte, 1 = half, 2 = word (used on the uncached path only)
//  p_rw      in   1      0 = read, 1 = write
//  p_ready   out  1      access done this cycle
//  m_a       out  32     memory address
//  m_dout    in   32     memory read data
//  m_din     out  32     memory write data
//  m_strobe  out  1      memory request; held with stable m_a/m_din/m_rw until m_ready
//  m_wen     out  4      memory byte enables
//  m_size    out  2      memory access size
//  m_rw      out  1      0 = read, 1 = write
//  m_ready   in   1      memory transfer complete (one-cycle pulse)
// BEHAVIOUR
//  - Reset (async): state=IDLE, all valid/dirty/LRU bits=0, m_strobe=0, p_ready=0. Reset mid-miss aborts the memory request at once.
//  - Set storage: per way valid, dirty, tag, 4 byte lanes. Per set: 1 LRU bit naming the least-recently-used way.
//  - Hit = p_strobe & cached & valid[w] & tag match. On a hit, p_ready=1 in the same cycle (0-wait).
//    p_din = hit way data. Stores merge bytes per p_wen and set dirty. LRU bit = other way.
//  - Both ways matching is impossible by construction; if it occurs, way0 wins.
//  - Victim on miss: the first invalid way (way0 first), else the way named by LRU. The victim is latched at miss detection.
//  - FSM:
//      IDLE -> WB  on cached miss with a dirty victim
//      IDLE -> RF  on cached miss with a clean victim
//      WB   -> RF  on m_ready
//      RF   -> IDLE on m_ready
//  - WB: m_a={victim tag, index, 2'b00}, m_din=victim data, m_rw=1, m_wen=4'hF, m_size=2.
//  - RF: m_a={p_a[31:2], 2'b00}, m_rw=0, m_wen=4'hF, m_size=2.
//    On m_ready: victim way <= m_dout, valid=1, dirty=0, tag written, LRU = other way.
//    p_ready stays 0 here; the access retries in IDLE the next cycle and hits.
//  - Miss latency: clean victim = memory latency + 1 cycle; dirty victim = 2 memory transfers + 1 cycle.
//  - If p_strobe drops during WB or RF, the memory transfer in flight still completes, then the FSM returns to IDLE.
//  - Uncached (FSM in IDLE): m_* = p_* directly (address translated), p_din = m_dout, p_ready = m_ready.
//    Cache arrays and LRU are untouched.
//  - p_ready=0 whenever p_strobe=0. m_strobe=0 in IDLE unless an uncached request is active.
// CONFIGURATION
//  D_CACHE_STATS_EN defined:
//    adds outputs hit_cnt[31:0] and miss_cnt[31:0], both 0 on reset.
//    hit_cnt increments on each cycle with a cached hit and p_ready; miss_cnt increments on each IDLE->WB/RF transition.
//    Both wrap at 2^32. Uncached accesses are not counted.
//  Undefined: the ports and counters do not exist; behaviour is otherwise identical.
// TESTING
//  1 Reset, then read 0x8000_0010 -> RF with m_a=0x8000_0010. m_dout=0x1122_3344 -> next cycle p_ready=1, p_din=0x1122_3344.
//  2 Fill both ways of one set (0x8000_0010, 0x8001_0010), read the first, then miss on 0x8002_0010
//    -> the second way (LRU) is evicted; a re-read of 0x8000_0010 hits.
//  3 sb 0xAB with p_wen=4'b0100 to a hit line, then force eviction -> WB with m_rw=1 and m_din showing 0xAB in [23:16],
//    followed by RF.
//  4 Uncached lw 0xBFC0_0000 -> m_a=0x1FC0_0000, p_ready mirrors m_ready, no cache state change (a subsequent cached read still misses).
//  5 Assert rst during RF with m_strobe=1 -> m_strobe=0 immediately; after release, the earlier hit address misses.
//  6 With D_CACHE_STATS_EN, run scenario 2 -> miss_cnt=3, hit_cnt=4 (3 post-refill retries + 1 explicit hit).

Source files
------------

// File: rtl/d_cache_2way.sv
// Two-way set-associative write-back/write-allocate data cache, one-word lines, LRU replacement.
// Optional hit/miss counters when D_CACHE_STATS_EN is defined.
`ifndef D_CACHE_INDEX
`define D_CACHE_INDEX 4
`endif
module d_cache_2way #(
  parameter int A_WIDTH = 32,
  parameter int C_INDEX = `D_CACHE_INDEX
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [A_WIDTH-1:0] p_a,
  input  logic [31:0]        p_dout,
  output logic [31:0]        p_din,
  input  logic               p_strobe,
  input  logic [3:0]         p_wen,
  input  logic [1:0]         p_size,
  input  logic               p_rw,
  output logic               p_ready,
  output logic [A_WIDTH-1:0] m_a,
  input  logic [31:0]        m_dout,
  output logic [31:0]        m_din,
  output logic               m_strobe,
  output logic [3:0]         m_wen,
  output logic [1:0]         m_size,
  output logic               m_rw,
`ifdef D_CACHE_STATS_EN
  output logic [31:0]        hit_cnt,
  output logic [31:0]        miss_cnt,
`endif
  input  logic               m_ready
);
  localparam int SETS  = 1 << C_INDEX;
  localparam int TAG_W = A_WIDTH - C_INDEX - 2;

  typedef enum logic [1:0] {S_IDLE, S_WB, S_RF} state_t;
  state_t state_q, state_d;

  logic [1:0][SETS-1:0] valid_q, dirty_q;
  logic [SETS-1:0]      lru_q;
  logic [TAG_W-1:0]     tag_q  [2][SETS];
  logic [31:0]          data_q [2][SETS];
  logic [A_WIDTH-1:0]   addr_q;
  logic                 victim_q;

  logic [C_INDEX-1:0] idx, idx_q;
  logic [TAG_W-1:0]   tag, tag_aq;
  logic cached, match0, match1, hit_way, lookup, hit, miss, victim;
  logic [31:0] merged;

  assign cached  = p_a[A_WIDTH-1:A_WIDTH-3] != 3'b101;
  assign idx     = p_a[C_INDEX+1:2];
  assign tag     = p_a[A_WIDTH-1:C_INDEX+2];
  assign idx_q   = addr_q[C_INDEX+1:2];
  assign tag_aq  = addr_q[A_WIDTH-1:C_INDEX+2];
  assign match0  = valid_q[0][idx] && (tag_q[0][idx] == tag);
  assign match1  = valid_q[1][idx] && (tag_q[1][idx] == tag);
  assign hit_way = ~match0;  // way0 wins on a double match
  assign lookup  = (state_q == S_IDLE) && p_strobe && cached;
  assign hit     = lookup && (match0 || match1);
  assign miss    = lookup && !(match0 || match1);
  assign victim  = !valid_q[0][idx] ? 1'b0 : (!valid_q[1][idx] ? 1'b1 : lru_q[idx]);

  always_comb begin
    merged = data_q[hit_way][idx];
    for (int b = 0; b < 4; b++)
      if (p_wen[b]) merged[b*8 +: 8] = p_dout[b*8 +: 8];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (miss) state_d = dirty_q[victim][idx] ? S_WB : S_RF;
      S_WB:   if (m_ready) state_d = S_RF;
      S_RF:   if (m_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    p_din    = data_q[hit_way][idx];
    p_ready  = 1'b0;
    m_a      = '0;
    m_din    = '0;
    m_strobe = 1'b0;
    m_wen    = 4'hF;
    m_size   = 2'd2;
    m_rw     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (p_strobe && !cached) begin
          m_a      = {3'b000, p_a[A_WIDTH-4:0]};
          m_din    = p_dout;
          m_strobe = 1'b1;
          m_wen    = p_wen;
          m_size   = p_size;
          m_rw     = p_rw;
          p_din    = m_dout;
          p_ready  = m_ready;
        end else if (hit) begin
          p_ready = 1'b1;
        end
      end
      S_WB: begin
        m_a      = {tag_q[victim_q][idx_q], idx_q, 2'b00};
        m_din    = data_q[victim_q][idx_q];
        m_strobe = 1'b1;
        m_rw     = 1'b1;
      end
      S_RF: begin
        m_a      = {addr_q[A_WIDTH-1:2], 2'b00};
        m_strobe = 1'b1;
      end
      default: ;
    endcase
  end

  // Miss context is latched so the transfer completes even if the CPU drops its request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= '0;
      dirty_q  <= '0;
      lru_q    <= '0;
      addr_q   <= '0;
      victim_q <= 1'b0;
    end else begin
      if (miss) begin
        addr_q   <= p_a;
        victim_q <= victim;
      end
      if (hit) begin
        lru_q[idx] <= ~hit_way;
        if (p_rw) dirty_q[hit_way][idx] <= 1'b1;
      end
      if (state_q == S_RF && m_ready) begin
        valid_q[victim_q][idx_q] <= 1'b1;
        dirty_q[victim_q][idx_q] <= 1'b0;
        lru_q[idx_q]             <= ~victim_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (hit && p_rw) data_q[hit_way][idx] <= merged;
    if (state_q == S_RF && m_ready) begin
      data_q[victim_q][idx_q] <= m_dout;
      tag_q[victim_q][idx_q]  <= tag_aq;
    end
  end

`ifdef D_CACHE_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (hit)  hit_cnt  <= hit_cnt + 32'd1;
      if (miss) miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

  logic unused_ok;
  assign unused_ok = ^p_size;
endmodule

// File: tb/tb_d_cache_2way.sv
// Directed bench for d_cache_2way: vector table plus hand sequences for reset and write-back.
module tb_d_cache_2way;
  logic        clk, rst;
  logic [31:0] p_a, p_dout, p_din, m_a, m_dout, m_din;
  logic        p_strobe, p_rw, p_ready, m_strobe, m_rw, m_ready;
  logic [3:0]  p_wen, m_wen;
  logic [1:0]  p_size, m_size;
`ifdef D_CACHE_STATS_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  d_cache_2way dut (
    .clk(clk), .rst(rst), .p_a(p_a), .p_dout(p_dout), .p_din(p_din), .p_strobe(p_strobe),
    .p_wen(p_wen), .p_size(p_size), .p_rw(p_rw), .p_ready(p_ready), .m_a(m_a), .m_dout(m_dout),
    .m_din(m_din), .m_strobe(m_strobe), .m_wen(m_wen), .m_size(m_size), .m_rw(m_rw),
`ifdef D_CACHE_STATS_EN
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt),
`endif
    .m_ready(m_ready));

  initial clk = 0;
  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  // Memory model: one-cycle latency responder
  logic [31:0] mem [logic [31:0]];
  logic [31:0] last_a, wb_a, wb_din;
  logic        last_rw;

  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : (a ^ 32'hDEAD_BEEF);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ready <= 1'b0;
    end else if (m_ready) begin
      if (m_strobe) begin
        last_a  <= m_a;
        last_rw <= m_rw;
        if (m_rw) begin
          logic [31:0] w;
          w = rd_mem(m_a);
          for (int b = 0; b < 4; b++) if (m_wen[b]) w[b*8 +: 8] = m_din[b*8 +: 8];
          mem[m_a] = w;
          wb_a   <= m_a;
          wb_din <= m_din;
        end
      end
      m_ready <= 1'b0;
    end else if (m_strobe) begin
      m_ready <= 1'b1;
      m_dout  <= rd_mem(m_a);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic access(input logic [31:0] a, input logic rw, input logic [3:0] wen,
                        input logic [1:0] size, input logic [31:0] wd,
                        output logic [31:0] rdat, output int cyc);
    p_a = a; p_rw = rw; p_wen = wen; p_size = size; p_dout = wd; p_strobe = 1'b1;
    cyc = 0;
    #1;
    while (!p_ready && cyc < 50) begin
      @(negedge clk); #1;
      cyc++;
    end
    rdat = p_din;
    @(negedge clk);
    p_strobe = 1'b0;
  endtask

  typedef struct {
    logic [31:0] a;
    logic        rw;
    logic [3:0]  wen;
    logic [1:0]  size;
    logic [31:0] wd;
    logic [31:0] exp_d;
    int          exp_cyc;
  } vec_t;

  localparam logic [31:0] A = 32'h8000_0010, B = 32'h8001_0010, C = 32'h8002_0010;
  vec_t v[16];

  initial begin
    logic [31:0] rdat;
    int cyc;

    v[0]  = '{A, 1'b0, 4'hF, 2'd2, 32'h0, 32'h1122_3344, 3};
    v[1]  = '{B, 1'b0, 4'hF, 2'd2, 32'h0, 32'h5566_7788, 3};
    v[2]  = '{A, 1'b0, 4'hF, 2'd2, 32'h0, 32'h1122_3344, 0};
    v[3]  = '{C, 1'b0, 4'hF, 2'd2, 32'h0, 32'h99AA_BBCC, 3};
    v[4]  = '{A, 1'b0, 4'hF, 2'd2, 32'h0, 32'h1122_3344, 0};
    v[5]  = '{B, 1'b0, 4'hF, 2'd2, 32'h0, 32'h5566_7788, 3};
    v[6]  = '{A, 1'b1, 4'b0100, 2'd0, 32'h00AB_0000, 32'h0, 0};
    v[7]  = '{A, 1'b0, 4'hF, 2'd2, 32'h0, 32'h11AB_3344, 0};
    v[8]  = '{C, 1'b0, 4'hF, 2'd2, 32'h0, 32'h99AA_BBCC, 3};
    v[9]  = '{B, 1'b0, 4'hF, 2'd2, 32'h0, 32'h5566_7788, 5};
    v[10] = '{A, 1'b0, 4'hF, 2'd2, 32'h0, 32'h11AB_3344, 3};
    v[11] = '{B, 1'b1, 4'hF, 2'd2, 32'hCAFE_F00D, 32'h0, 0};
    v[12] = '{B, 1'b0, 4'hF, 2'd2, 32'h0, 32'hCAFE_F00D, 0};
    v[13] = '{32'hBFC0_0000, 1'b0, 4'hF, 2'd2, 32'h0, 32'h3C1A_BFC0, 1};
    v[14] = '{32'hA000_0100, 1'b1, 4'b0011, 2'd1, 32'h0000_BEEF, 32'h0, 1};
    v[15] = '{32'h9FC0_0000, 1'b0, 4'hF, 2'd2, 32'h0, 32'h416D_BEEF, 3};

    mem[A] = 32'h1122_3344;
    mem[B] = 32'h5566_7788;
    mem[C] = 32'h99AA_BBCC;
    mem[32'h1FC0_0000] = 32'h3C1A_BFC0;

    p_a = '0; p_dout = '0; p_strobe = 0; p_wen = '0; p_size = '0; p_rw = 0;
    rst = 1;
    #1;
    chk("reset_p_ready", {31'b0, p_ready}, 32'd0);
    chk("reset_m_strobe", {31'b0, m_strobe}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      access(v[i].a, v[i].rw, v[i].wen, v[i].size, v[i].wd, rdat, cyc);
      chk($sformatf("vec%0d_cycles", i), cyc, v[i].exp_cyc);
      if (!v[i].rw) chk($sformatf("vec%0d_data", i), rdat, v[i].exp_d);
      if (i == 0) begin
        chk("refill_addr", last_a, A);
        chk("refill_rw", {31'b0, last_rw}, 32'd0);
      end
`ifdef D_CACHE_STATS_EN
      if (i == 3) begin
        chk("miss_cnt", miss_cnt, 32'd3);
        chk("hit_cnt", hit_cnt, 32'd4);
      end
`endif
      if (i == 9) begin
        chk("wb_addr", wb_a, A);
        chk("wb_data", wb_din, 32'h11AB_3344);
        chk("wb_byte2", {24'b0, wb_din[23:16]}, 32'h0000_00AB);
      end
      if (i == 13) chk("uncached_addr", last_a, 32'h1FC0_0000);
      if (i == 14) chk("uncached_store", rd_mem(32'h0000_0100), 32'hDEAD_BEEF);
    end

    // A resides in the cache before the reset
    access(A, 1'b0, 4'hF, 2'd2, 32'h0, rdat, cyc);
    chk("pre_reset_hit", cyc, 0);

    // Reset while a refill is outstanding
    p_a = 32'h8004_0020; p_rw = 0; p_wen = 4'hF; p_size = 2'd2; p_strobe = 1;
    cyc = 0;
    #1;
    while (!(m_strobe && !m_rw) && cyc < 20) begin
      @(negedge clk); #1;
      cyc++;
    end
    chk("rf_reached", {31'b0, m_strobe && !m_rw}, 32'd1);
    rst = 1;
    #1;
    chk("rst_mid_m_strobe", {31'b0, m_strobe}, 32'd0);
    chk("rst_mid_p_ready", {31'b0, p_ready}, 32'd0);
    p_strobe = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    repeat (2) @(negedge clk);
    access(A, 1'b0, 4'hF, 2'd2, 32'h0, rdat, cyc);
    chk("post_reset_miss_cycles", cyc, 3);
    chk("post_reset_data", rdat, 32'h11AB_3344);
    #1;
    chk("idle_p_ready", {31'b0, p_ready}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
